// File: rtl/paddle_pos_ctrl.sv
// paddle_pos_ctrl: frame-synchronous paddle position controller.
// Targets arrive over valid/ready and are clamped to the play field. The
// result is committed to x_loc/y_loc once per vertical-blank rise.
// Build option: define PADDLE_SLEW_EN to limit each per-frame move to
// +/-MAX_STEP per axis. Without it, the paddle jumps straight to the target.
module paddle_pos_ctrl #(
    parameter int FIELD_W  = 640,
    parameter int FIELD_H  = 480,
    parameter int PAD_W    = 102,
    parameter int PAD_H    = 76,
    parameter int MAX_STEP = 16,
    parameter int X_INIT   = 269,
    parameter int Y_INIT   = 202
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic        vblank,
    output logic [15:0] x_loc,
    output logic [15:0] y_loc,
    output logic [15:0] vel_x,
    output logic [15:0] vel_y,
    output logic        frame_done
);

    localparam logic signed [15:0] X_MAX    = 16'(FIELD_W - PAD_W);
    localparam logic signed [15:0] Y_MAX    = 16'(FIELD_H - PAD_H);
    localparam logic signed [16:0] STEP_LIM = 17'(MAX_STEP);

    typedef enum logic [1:0] {IDLE, CLAMP, STEP, COMMIT} state_t;

    state_t             state, state_nxt;
    logic               vblank_q;
    logic               vb_rise;
    logic [15:0]        tgt_x, tgt_y;
    logic [15:0]        snap_x, snap_y;
    logic [15:0]        clmp_x, clmp_y;
    logic signed [16:0] d_x, d_y;

    // Pull a signed target back inside [0, max].
    function automatic logic [15:0] clamp_axis(input logic signed [15:0] v,
                                               input logic signed [15:0] max);
        if (v < 0)
            return 16'd0;
        else if (v > max)
            return max;
        else
            return v;
    endfunction

    // Signed distance to the clamped target, optionally slew-limited.
    // Both operands lie in 0..max, so the result always fits in 17 bits.
    function automatic logic signed [16:0] step_axis(input logic [15:0] tgt,
                                                     input logic [15:0] cur);
        logic signed [16:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
`ifdef PADDLE_SLEW_EN
        if (d > STEP_LIM)
            d = STEP_LIM;
        else if (d < -STEP_LIM)
            d = -STEP_LIM;
`endif
        return d;
    endfunction

    assign vb_rise = vblank && !vblank_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state; only IDLE accepts targets or reacts to vblank.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (vb_rise)
                    state_nxt = CLAMP;
            end
            CLAMP:   state_nxt = STEP;
            STEP:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: target capture, snapshot, clamp, step, commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q   <= 1'b0;
            tgt_x      <= 16'(X_INIT);
            tgt_y      <= 16'(Y_INIT);
            snap_x     <= 16'(X_INIT);
            snap_y     <= 16'(Y_INIT);
            clmp_x     <= 16'(X_INIT);
            clmp_y     <= 16'(Y_INIT);
            d_x        <= '0;
            d_y        <= '0;
            x_loc      <= 16'(X_INIT);
            y_loc      <= 16'(Y_INIT);
            vel_x      <= '0;
            vel_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            frame_done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tgt_x <= req_x;
                        tgt_y <= req_y;
                    end
                    // A same-edge request wins over the stored target.
                    if (vb_rise) begin
                        snap_x <= req_valid ? req_x : tgt_x;
                        snap_y <= req_valid ? req_y : tgt_y;
                    end
                end
                CLAMP: begin
                    clmp_x <= clamp_axis(snap_x, X_MAX);
                    clmp_y <= clamp_axis(snap_y, Y_MAX);
                end
                STEP: begin
                    d_x <= step_axis(clmp_x, x_loc);
                    d_y <= step_axis(clmp_y, y_loc);
                end
                COMMIT: begin
                    x_loc <= 16'($signed({1'b0, x_loc}) + d_x);
                    y_loc <= 16'($signed({1'b0, y_loc}) + d_y);
                    vel_x <= 16'(d_x);
                    vel_y <= 16'(d_y);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Bench for paddle_pos_ctrl: directed cases plus randomized frames, all
// checked against a frame-level reference model.
module tb_paddle_pos_ctrl;

    localparam int XM = 538;
    localparam int YM = 404;
    localparam int MS = 16;
`ifdef PADDLE_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic        vblank = 1'b0;
    logic [15:0] x_loc, y_loc, vel_x, vel_y;
    logic        frame_done;

    int n_chk = 0;
    int n_fail = 0;

    // Model: target, snapshot, position, velocity, cycles since accepted rise.
    int m_tx, m_ty, m_sx, m_sy, m_px, m_py, m_vx, m_vy, m_busy;
    bit m_vbq, m_fd;

    paddle_pos_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .vblank     (vblank),
        .x_loc      (x_loc),
        .y_loc      (y_loc),
        .vel_x      (vel_x),
        .vel_y      (vel_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lim(input int v, input int m);
        return (v < 0) ? 0 : ((v > m) ? m : v);
    endfunction

    function automatic int slew(input int d);
        if (!SLEW) return d;
        return (d > MS) ? MS : ((d < -MS) ? -MS : d);
    endfunction

    task automatic model_reset();
        m_tx = 269; m_ty = 202; m_sx = 269; m_sy = 202;
        m_px = 269; m_py = 202; m_vx = 0;   m_vy = 0;
        m_busy = 0; m_vbq = 1'b0; m_fd = 1'b0;
    endtask

    // Advance the model by one clock edge, using the inputs applied before it.
    task automatic model_edge();
        int dx, dy;
        m_fd = 1'b0;
        if (m_busy == 0) begin
            if (req_valid) begin
                m_tx = $signed(req_x);
                m_ty = $signed(req_y);
            end
            if (vblank && !m_vbq) begin
                m_sx = m_tx; m_sy = m_ty; m_busy = 1;
            end
        end else if (m_busy == 3) begin
            dx = slew(lim(m_sx, XM) - m_px);
            dy = slew(lim(m_sy, YM) - m_py);
            m_px += dx; m_py += dy; m_vx = dx; m_vy = dy;
            m_fd = 1'b1; m_busy = 0;
        end else begin
            m_busy++;
        end
        m_vbq = vblank;
    endtask

    task automatic check_all();
        chk("x_loc", x_loc, m_px);
        chk("y_loc", y_loc, m_py);
        chk("vel_x", $signed(vel_x), m_vx);
        chk("vel_y", $signed(vel_y), m_vy);
        chk("frame_done", frame_done, int'(m_fd));
        chk("req_ready", req_ready, int'(m_busy == 0));
    endtask

    // One clock: drive at negedge, model at posedge, check at the next negedge.
    task automatic cyc(input bit v, input int rx, input int ry, input bit vb);
        req_valid = v; req_x = 16'(rx); req_y = 16'(ry); vblank = vb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic frame(input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < lo; i++) cyc(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int busy_cnt, fd_cnt;
        int exp_x [3];
        int exp_v [3];

        // Power-on reset
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);

        // Clamp: out-of-field target
        cyc(1'b1, -5, 1000, 1'b0);
        frame(4, 2);
        chk("clamp_x", x_loc, SLEW ? 253 : 0);
        chk("clamp_y", y_loc, SLEW ? 218 : 404);
        chk("clamp_vx", $signed(vel_x), SLEW ? -16 : -269);

        // Reset while in STEP
        cyc(1'b1, 500, 50, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_x", x_loc, 269);
        chk("rst_y", y_loc, 202);
        chk("rst_vx", $signed(vel_x), 0);
        chk("rst_ready", req_ready, 1);
        vblank = 1'b0;
        @(negedge clk);
        chk("rst_no_pulse", frame_done, 0);
        check_all();
        rst_n = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);

        // Slew convergence toward (300,202)
        exp_x = SLEW ? '{285, 300, 300} : '{300, 300, 300};
        exp_v = SLEW ? '{16, 15, 0} : '{31, 0, 0};
        cyc(1'b1, 300, 202, 1'b0);
        for (int f = 0; f < 3; f++) begin
            fd_cnt = 0;
            for (int i = 0; i < 6; i++) begin
                cyc(1'b0, 0, 0, i < 4);
                if (frame_done) fd_cnt++;
            end
            chk("conv_x", x_loc, exp_x[f]);
            chk("conv_vx", $signed(vel_x), exp_v[f]);
            chk("conv_pulse", fd_cnt, 1);
        end

        // Last-wins, with the final request on the rise edge
        cyc(1'b1, 100, 100, 1'b0);
        cyc(1'b1, 400, 300, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (!req_ready) busy_cnt++;
            cyc(1'b1, 7, 7, i < 3);
        end
        chk("busy_cycles", busy_cnt, 3);
        chk("same_edge_x", x_loc, SLEW ? 316 : 400);
        chk("same_edge_y", y_loc, SLEW ? 218 : 300);

        // Vblank glitch while busy: exactly one commit
        cyc(1'b1, 10, 10, 1'b0);
        fd_cnt = 0;
        foreach (exp_x[i]) ;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 0, 0, (i == 0) || (i >= 2 && i < 7));
            if (frame_done) fd_cnt++;
        end
        chk("glitch_commits", fd_cnt, 1);

        // Randomized frames: busy video with requests, then vblank
        for (int f = 0; f < 80; f++) begin
            int act, blk;
            act = $urandom_range(30, 6);
            blk = $urandom_range(8, 1);
            for (int i = 0; i < act; i++)
                cyc($urandom_range(1, 0) == 1, $urandom_range(800, 0) - 100,
                    $urandom_range(660, 0) - 100, $urandom_range(19, 0) == 0);
            for (int i = 0; i < blk; i++)
                cyc($urandom_range(3, 0) == 0, $urandom_range(800, 0) - 100,
                    $urandom_range(660, 0) - 100, $urandom_range(7, 0) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_pos_ctrl.md
# paddle_pos_ctrl

Frame-synchronous position controller for a paddle sprite renderer. Accepts target positions from the input path (mouse/network) over a valid/ready handshake, clamps them to the play field, slew-limits the motion, and commits new `x_loc`/`y_loc` only at the start of vertical blank, so the renderer sees a stable position for the whole active frame. Also reports per-frame velocity for the ball-spin ("curve") logic, plus a commit strobe.

## Interface
- `FIELD_W`, 640: play-field width in pixels.
- `FIELD_H`, 480: play-field height in pixels.
- `PAD_W`, 102: paddle width. Extent is 0..101, so the max x is `FIELD_W-PAD_W` = 538.
- `PAD_H`, 76: paddle height. Max y = 404.
- `MAX_STEP`, 16: maximum per-frame move, per axis, in pixels.
- `X_INIT`, 269: reset x position.
- `Y_INIT`, 202: reset y position.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  target request valid.
- `req_ready`  out  1  controller can accept a target.
- `req_x`  in  16  target x, signed two's complement.
- `req_y`  in  16  target y, signed two's complement.
- `vblank`  in  1  vertical-blank level from the VGA timing generator.
- `x_loc`  out  16  committed paddle x, unsigned.
- `y_loc`  out  16  committed paddle y, unsigned.
- `vel_x`  out  16  signed (new x_loc − old x_loc) at the last commit.
- `vel_y`  out  16  signed (new y_loc − old y_loc) at the last commit.
- `frame_done`  out  1  one-cycle pulse after each commit.

## Operation
- **Reset values:** `x_loc=X_INIT`, `y_loc=Y_INIT`, `vel_x=vel_y=0`, `frame_done=0`, `req_ready=1`, FSM=IDLE, target=(X_INIT,Y_INIT), `vblank_q=0`.
- **Request acceptance:**
  - A transfer occurs on a `clk` edge where `req_valid && req_ready`.
  - It overwrites the target register. Last accepted request wins; there is no queue.
- **`req_ready`:** equals 1 only in IDLE.
- **Vblank rise:** `vblank && !vblank_q`. `vblank_q` is registered every cycle.
- **FSM states:** IDLE, CLAMP, STEP, COMMIT.
  - **IDLE → CLAMP** on vblank rise. A snapshot of the target is taken on that edge. If a request transfers on the same edge, the new request is the one snapshotted.
  - **CLAMP → STEP** (unconditional).
    - x: negative → 0; greater than `FIELD_W-PAD_W` → `FIELD_W-PAD_W`; otherwise pass-through.
    - y: same rule against `FIELD_H-PAD_H`.
  - **STEP → COMMIT** (unconditional).
    - Compute `d = clamped − current` as 17-bit signed.
    - With slew: limit `d` to [−MAX_STEP, +MAX_STEP].
    - `next = current + d`.
  - **COMMIT → IDLE.**
    - Load `x_loc`/`y_loc` with `next`.
    - `vel_x`/`vel_y` = `d` truncated to 16 bits.
    - Assert `frame_done` for the following cycle.
- **Target persistence:** the target persists across frames. With no new request, the paddle keeps stepping toward the last target and then holds with velocity 0.
- **Outputs:** never change outside COMMIT.
- **Vblank edges while busy:** a vblank fall or rise while not in IDLE is ignored. No rise is missed in practice, since the frame is ≫ 4 cycles.
- **Reset mid-operation:** `rst_n` low in any state returns every register to its reset value immediately. A partial commit is impossible.

## Timing
- Let edge k be the edge with vblank rise. The FSM is in CLAMP after k, STEP after k+1, COMMIT after k+2.
- `x_loc`/`y_loc`/`vel_*` update on edge k+3.
- `frame_done`=1 for the cycle between k+3 and k+4.
- `req_ready`=0 from after edge k until after edge k+3. It is 1 again in the cycle that `frame_done` is high.
- Latency from vblank rise to a visible new position: 3 clocks.
- Throughput: 1 accepted request per cycle while in IDLE.

## Configuration
- **`PADDLE_SLEW_EN` defined:** the STEP state applies the ±`MAX_STEP` limit.
- **`PADDLE_SLEW_EN` undefined:** STEP passes `d` unmodified. The paddle jumps to the clamped target in one frame, and `vel_*` reports the full jump. FSM states and timing are identical in both builds.

## Test plan
- **Reset:** assert `rst_n=0` mid-STEP → `x_loc=269`, `y_loc=202`, `vel=0`, `req_ready=1` immediately, with no `frame_done` pulse.
- **Clamp:** request (−5, 1000), then vblank rise → after 3 clocks `x_loc=0`, `y_loc=404` (slew off). With slew on, the result is `x_loc=253`, `y_loc=218`, `vel=(−16,+16)`.
- **Slew convergence (slew on):** request (300, 202) from (269, 202). Over successive frames, `x_loc` goes 285, 300, 300 and `vel_x` goes 16, 15, 0. `frame_done` pulses every frame.
- **Last-wins and same-edge:** requests (100,100) then (400,300), the latter transferring on the vblank-rise edge → the commit moves toward (400,300). `req_ready=0` for exactly 3 cycles.
- **Frame stability:** requests every cycle throughout active video → `x_loc`/`y_loc` change only on the edge k+3 following each vblank rise.
- **Vblank glitch:** vblank toggles 1-0-1 within the 3 busy cycles → exactly one commit, and no second FSM pass until the next clean rise.
